// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI responder slice.
package spi_responder_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] FILL_DEFAULT = 8'hFF;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SELECTED = 1'b1
  } state_t;

endpackage

// File: rtl/spi_responder_if.sv
// Local-side byte exchange between the SPI responder (slave) and the logic it serves (master).
interface spi_responder_if;
  import spi_responder_pkg::*;

  // Handshakes: a byte moves on the posedge where VALID and READY are both high;
  // the VALID side holds its data stable until then, and READY never waits on VALID.
  logic [BYTE_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic [BYTE_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              OVERRUN;
  logic              CLR_OVR;
  logic              FRAME_ERR;
  logic              BUSY;
  state_t            state_dbg;

  modport slave (
    input  TX_DATA, TX_VALID, RX_READY, CLR_OVR,
    output TX_READY, RX_DATA, RX_VALID, OVERRUN, FRAME_ERR, BUSY, state_dbg
  );

  modport master (
    output TX_DATA, TX_VALID, RX_READY, CLR_OVR,
    input  TX_READY, RX_DATA, RX_VALID, OVERRUN, FRAME_ERR, BUSY, state_dbg
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with single-cycle rise/fall pulses.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      dly   <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~dly;
  assign fall  = ~chain[STAGES-1] & dly;

endmodule

// File: rtl/spi_responder.sv
// SPI CPHA=0 responder: oversampled pins, byte-wide valid/ready exchange with local logic.
// Define SPI_RX_FIFO_EN to buffer received bytes in an RX_FIFO_DEPTH-entry FIFO.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int                SYNC_STAGES   = 2,
  parameter logic [BYTE_W-1:0] FILL          = FILL_DEFAULT,
  parameter int                RX_FIFO_DEPTH = 4
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic SCK,
  input  logic MOSI,
  input  logic nSS,
  input  logic CPOL,
  output logic MISO,
  output logic MISO_OE,
  spi_responder_if.slave bus
);

  logic sck_rise, sck_fall, nss_rise, nss_fall, mosi_s;
  logic sck_level_unused, nss_level_unused, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(CLK), .rst_n(nRESET), .din(SCK),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // Resetting the nSS chain low means a select already asserted at release yields no falling edge.
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_nss (
    .clk(CLK), .rst_n(nRESET), .din(nSS),
    .level(nss_level_unused), .rise(nss_rise), .fall(nss_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(CLK), .rst_n(nRESET), .din(MOSI),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t            state;
  logic [2:0]        bitcnt;
  logic [BYTE_W-2:0] rxsh;
  logic [BYTE_W-2:0] tx_rest;
  logic [BYTE_W-1:0] tx_hold, tx_load, rx_byte;
  logic sample_edge, shift_edge, active, load_ev, byte_done;
  logic tx_accept, tx_consume, rx_pop, ovr_set;

  always_comb begin
    sample_edge = CPOL ? sck_fall : sck_rise;
    shift_edge  = CPOL ? sck_rise : sck_fall;
    active      = (state == ST_SELECTED) && !nss_rise;
    load_ev     = ((state == ST_IDLE) && nss_fall) ||
                  (active && shift_edge && (bitcnt == 3'd0));
    byte_done   = active && sample_edge && (bitcnt == 3'd7);
    tx_load     = bus.TX_READY ? FILL : tx_hold;
    tx_accept   = bus.TX_VALID && bus.TX_READY;
    tx_consume  = load_ev && !bus.TX_READY;
    rx_byte     = {rxsh, mosi_s};
    rx_pop      = bus.RX_VALID && bus.RX_READY;
  end

  // MISO is the top bit of the TX shifter; tx_rest holds the bits still to go.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state         <= ST_IDLE;
      bitcnt        <= 3'd0;
      rxsh          <= '0;
      tx_rest       <= '0;
      MISO          <= 1'b1;
      MISO_OE       <= 1'b0;
      bus.BUSY      <= 1'b0;
      bus.FRAME_ERR <= 1'b0;
    end else begin
      bus.FRAME_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (nss_fall) begin
            state    <= ST_SELECTED;
            bitcnt   <= 3'd0;
            MISO     <= tx_load[BYTE_W-1];
            tx_rest  <= tx_load[BYTE_W-2:0];
            MISO_OE  <= 1'b1;
            bus.BUSY <= 1'b1;
          end
        end
        ST_SELECTED: begin
          if (nss_rise) begin
            state         <= ST_IDLE;
            bus.FRAME_ERR <= (bitcnt != 3'd0);
            bitcnt        <= 3'd0;
            MISO          <= 1'b1;
            MISO_OE       <= 1'b0;
            bus.BUSY      <= 1'b0;
          end else if (sample_edge) begin
            rxsh   <= rx_byte[BYTE_W-2:0];
            bitcnt <= bitcnt + 3'd1;
          end else if (shift_edge) begin
            if (bitcnt == 3'd0) begin
              MISO    <= tx_load[BYTE_W-1];
              tx_rest <= tx_load[BYTE_W-2:0];
            end else begin
              MISO    <= tx_rest[BYTE_W-2];
              tx_rest <= {tx_rest[BYTE_W-3:0], 1'b0};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.state_dbg = state;

  // TX_READY doubles as "holding register empty", so accept and consume are exclusive.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bus.TX_READY <= 1'b1;
      tx_hold      <= '0;
    end else if (tx_accept) begin
      bus.TX_READY <= 1'b0;
      tx_hold      <= bus.TX_DATA;
    end else if (tx_consume) begin
      bus.TX_READY <= 1'b1;
    end
  end

`ifdef SPI_RX_FIFO_EN
  localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [BYTE_W-1:0] rx_mem [RX_FIFO_DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              fifo_full, push;

  assign fifo_full    = (wptr ^ rptr) == FULL_XOR;
  assign push         = byte_done && (!fifo_full || rx_pop);
  assign ovr_set      = byte_done && !push;
  assign bus.RX_VALID = (wptr != rptr);
  assign bus.RX_DATA  = rx_mem[rptr[AW-1:0]];

  // The FIFO survives deselect; only reset empties it.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (push) begin
        rx_mem[wptr[AW-1:0]] <= rx_byte;
        wptr                 <= wptr + PTR_ONE;
      end
      if (rx_pop) rptr <= rptr + PTR_ONE;
    end
  end
`else
  localparam int rx_fifo_depth_unused = RX_FIFO_DEPTH;

  assign ovr_set = byte_done && bus.RX_VALID && !bus.RX_READY;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bus.RX_DATA  <= '0;
      bus.RX_VALID <= 1'b0;
    end else if (byte_done && !ovr_set) begin
      bus.RX_DATA  <= rx_byte;
      bus.RX_VALID <= 1'b1;
    end else if (rx_pop) begin
      bus.RX_VALID <= 1'b0;
    end
  end
`endif

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)           bus.OVERRUN <= 1'b0;
    else if (ovr_set)      bus.OVERRUN <= 1'b1;
    else if (bus.CLR_OVR)  bus.OVERRUN <= 1'b0;
  end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: the bench acts as SPI master and checks against a byte-level model.
module tb_spi_responder;
  import spi_responder_pkg::*;

  localparam int H = 8;
  localparam logic [7:0] FILL_B = 8'hFF;
`ifdef SPI_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  logic SCK = 1'b0;
  logic MOSI = 1'b0;
  logic nSS = 1'b1;
  logic CPOL = 1'b0;
  logic MISO, MISO_OE;

  spi_responder_if bus ();

  spi_responder dut (
    .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .MOSI(MOSI), .nSS(nSS), .CPOL(CPOL),
    .MISO(MISO), .MISO_OE(MISO_OE), .bus(bus)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end

  // model state
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] cur_tx = 8'hFF;
  logic [7:0] m_rx = 8'h00;
  int         m_bits = 0;
  bit         m_sel = 1'b0;
  bit         m_ovr = 1'b0;
  int         fe_exp = 0;
  int         fe_cnt = 0;
  bit         fe_prev = 1'b0;
  int         rx_seen = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] ovr_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] next_tx();
    if (tx_q.size() > 0) return tx_q.pop_front();
    return FILL_B;
  endfunction

  task automatic rx_complete(input logic [7:0] b);
    if (exp_q.size() < RX_CAP) exp_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // scoreboard: every cycle RX_VALID is high the head must match the model
  always @(negedge CLK) begin
    if (!nRESET) begin
      fe_prev = 1'b0;
    end else begin
      if (bus.FRAME_ERR) begin
        fe_cnt++;
        if (fe_prev) begin
          n_tests++;
          n_fail++;
          $display("FAIL frame_err_width: FRAME_ERR high on consecutive cycles, expected one-cycle pulse");
        end
      end
      fe_prev = bus.FRAME_ERR;
      if (bus.RX_VALID) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: RX_VALID=1 with RX_DATA=%02h, expected no pending byte", bus.RX_DATA);
        end else begin
          check("rx_data", bus.RX_DATA, exp_q[0]);
          if (bus.RX_READY) begin
            void'(exp_q.pop_front());
            rx_last = bus.RX_DATA;
            rx_seen++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    int w = 0;
    while (!bus.TX_READY && w < 100) begin
      tick(1);
      w++;
    end
    check("tx_ready_wait", bus.TX_READY, 1'b1);
    bus.TX_DATA  = b;
    bus.TX_VALID = 1'b1;
    tick(1);
    bus.TX_VALID = 1'b0;
    bus.TX_DATA  = 8'h00;
    tx_q.push_back(b);
  endtask

  task automatic do_select();
    nSS = 1'b0;
    m_sel = 1'b1;
    m_bits = 0;
    cur_tx = next_tx();
    tick(H);
  endtask

  task automatic do_deselect();
    tick(H);
    if (m_sel && m_bits != 0) fe_exp++;
    nSS = 1'b1;
    m_sel = 1'b0;
    m_bits = 0;
    tick(H);
    check("busy_off", bus.BUSY, 1'b0);
    check("oe_off", MISO_OE, 1'b0);
    check("miso_off", MISO, 1'b1);
    check("frame_err_count", fe_cnt, fe_exp);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    MOSI = b;
    tick(H);
    seen = MISO;
    if (m_sel) check("miso_bit", MISO, cur_tx[7 - m_bits]);
    else       check("miso_idle", MISO, 1'b1);
    SCK = ~CPOL;
    if (m_sel) begin
      m_rx = {m_rx[6:0], b};
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        rx_complete(m_rx);
      end
    end
    tick(H);
    SCK = CPOL;
    if (m_sel && m_bits == 0) cur_tx = next_tx();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] seen);
    logic s;
    for (int i = 0; i < 8; i++) begin
      send_bit(b[7 - i], s);
      seen = {seen[6:0], s};
    end
  endtask

  task automatic check_reset_vals();
    check("rst_miso", MISO, 1'b1);
    check("rst_miso_oe", MISO_OE, 1'b0);
    check("rst_tx_ready", bus.TX_READY, 1'b1);
    check("rst_rx_data", bus.RX_DATA, 8'h00);
    check("rst_rx_valid", bus.RX_VALID, 1'b0);
    check("rst_overrun", bus.OVERRUN, 1'b0);
    check("rst_frame_err", bus.FRAME_ERR, 1'b0);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_state", bus.state_dbg, ST_IDLE);
  endtask

  initial begin
    logic [7:0] mb;
    logic       sb;
    int         seen0;
    bus.TX_DATA  = 8'h00;
    bus.TX_VALID = 1'b0;
    bus.RX_READY = 1'b0;
    bus.CLR_OVR  = 1'b0;

    // reset values
    tick(3);
    check_reset_vals();
    nRESET = 1'b1;
    tick(H);

    // mode 0, TX byte pending at select
    push_tx(8'hA5);
    check("tx_ready_full", bus.TX_READY, 1'b0);
    do_select();
    check("tx_ready_after_select", bus.TX_READY, 1'b1);
    check("busy_on", bus.BUSY, 1'b1);
    check("oe_on", MISO_OE, 1'b1);
    send_byte(8'h3C, mb);
    check("miso_byte_a5", mb, 8'hA5);
    check("rx_valid_held", bus.RX_VALID, 1'b1);
    check("rx_data_3c", bus.RX_DATA, 8'h3C);
    bus.RX_READY = 1'b1;
    tick(2);
    check("rx_last_3c", rx_last, 8'h3C);
    do_deselect();

    // no TX pending: FILL goes out, two bytes received
    seen0 = rx_seen;
    do_select();
    send_byte(8'h01, mb);
    check("miso_fill_0", mb, 8'hFF);
    send_byte(8'h80, mb);
    check("miso_fill_1", mb, 8'hFF);
    check("rx_count_2", rx_seen - seen0, 2);
    check("rx_last_80", rx_last, 8'h80);
    do_deselect();

    // consumer stalled: overrun once storage is full
    bus.RX_READY = 1'b0;
    do_select();
    for (int i = 0; i < RX_CAP; i++) send_byte(ovr_bytes[i], mb);
    check("overrun_before_full", bus.OVERRUN, 1'b0);
    send_byte(ovr_bytes[RX_CAP], mb);
    check("overrun_set", bus.OVERRUN, m_ovr);
    check("rx_head_11", bus.RX_DATA, 8'h11);
    bus.CLR_OVR = 1'b1;
    tick(1);
    bus.CLR_OVR = 1'b0;
    m_ovr = 1'b0;
    check("overrun_cleared", bus.OVERRUN, m_ovr);
    bus.RX_READY = 1'b1;
    tick(H);
    check("rx_drained", exp_q.size(), 0);
    do_deselect();

    // deselect mid-byte, then a clean byte from bit 0
    do_select();
    for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1, sb);
    do_deselect();
    do_select();
    send_byte(8'hC3, mb);
    check("rx_after_frame_err", rx_last, 8'hC3);
    do_deselect();

    // CPOL=1, SCK idles high
    CPOL = 1'b1;
    SCK  = 1'b1;
    tick(H);
    push_tx(8'h96);
    do_select();
    send_byte(8'h96, mb);
    check("miso_byte_96", mb, 8'h96);
    check("rx_cpol1_96", rx_last, 8'h96);
    do_deselect();
    CPOL = 1'b0;
    SCK  = 1'b0;
    tick(H);

    // reset mid-byte with select held low
    do_select();
    for (int i = 0; i < 3; i++) send_bit(1'b1, sb);
    nRESET = 1'b0;
    SCK = CPOL;
    exp_q.delete();
    tx_q.delete();
    m_sel = 1'b0;
    m_bits = 0;
    m_ovr = 1'b0;
    tick(2);
    check_reset_vals();
    nRESET = 1'b1;
    tick(H);
    send_byte(8'h5A, mb);
    check("oe_after_reset", MISO_OE, 1'b0);
    check("busy_after_reset", bus.BUSY, 1'b0);
    do_deselect();
    do_select();
    send_byte(8'h7E, mb);
    check("rx_after_reselect", rx_last, 8'h7E);
    do_deselect();

    tick(H);
    check("rx_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI target (responder) serving the bit-banged SPI master driven by Gigatron ctrl codes: SCK, MOSI and one active-low select.
- Used on the expansion side, for example in a peripheral CPLD or an SD-emulation test fixture, to answer the Gigatron's SPI transfers.
- Oversampled design: all SPI pins are synchronized into CLK, edges are detected in CLK, and bytes are exchanged with local logic through valid/ready handshakes.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on SCK, MOSI and nSS before edge detection; minimum 2.
- FILL, 8'hFF: byte shifted out on MISO when no TX byte is pending.
- RX_FIFO_DEPTH, 4: RX FIFO depth, power of two; used only with SPI_RX_FIFO_EN.

Ports:
- CLK  input  1  single system clock; all state is on posedge.
- nRESET  input  1  asynchronous, active-low reset.
- SCK  input  1  SPI clock from the master; asynchronous to CLK.
- MOSI  input  1  SPI data from the master, MSB first.
- nSS  input  1  active-low select from the master.
- CPOL  input  1  clock polarity, quasi-static; changed only while nSS is high.
- MISO  output  1  SPI data to the master.
- MISO_OE  output  1  high while selected; drives the external tristate.
- TX_DATA  input  8  next byte to send.
- TX_VALID  input  1  TX_DATA is valid.
- TX_READY  output  1  TX holding register is empty.
- RX_DATA  output  8  received byte.
- RX_VALID  output  1  RX_DATA is valid; held until accepted.
- RX_READY  input  1  local side accepts RX_DATA.
- OVERRUN  output  1  sticky flag: an RX byte was dropped.
- CLR_OVR  input  1  one-cycle pulse that clears OVERRUN.
- FRAME_ERR  output  1  one-cycle pulse: deselect occurred mid-byte.
- BUSY  output  1  high in SELECTED state.

Behaviour:
- Reset values:
  - MISO=1, MISO_OE=0, TX_READY=1, RX_DATA=8'h00, RX_VALID=0.
  - OVERRUN=0, FRAME_ERR=0, BUSY=0.
  - State IDLE, bit counter 0, TX holding register empty.
- Reset asserted mid-transfer aborts immediately.
  - After release, the block stays in IDLE until nSS goes high, then low again. A select already low at release is ignored.
- Synchronizer: SYNC_STAGES flip-flops per input. Edges are taken from the last stage against a one-cycle-delayed copy.
  - Latency from pin to action is SYNC_STAGES+1 CLK cycles.
  - Each SCK half-period must be at least SYNC_STAGES+2 CLK cycles.
- Mode is CPHA=0 only.
  - Sample edge is rising when CPOL=0, falling when CPOL=1.
  - Shift edge is the opposite edge.
- State machine:
  - IDLE to SELECTED on the synchronized nSS falling edge.
  - SELECTED to IDLE on the synchronized nSS rising edge.
  - In IDLE, SCK edges are ignored.
- Entering SELECTED:
  - bitcnt=0.
  - TX shift register is loaded from the holding register if it is full; the holding register then empties and TX_READY=1 on the next cycle. Otherwise it is loaded with FILL.
  - MISO=txsh[7]; MISO_OE=1; BUSY=1.
- Sample edge:
  - rxsh <= {rxsh[6:0], MOSI}; bitcnt <= bitcnt+1 (3 bits, wraps 7 to 0).
  - On bitcnt==7 the byte {rxsh[6:0], MOSI} completes.
    - If RX_VALID==0 or RX_READY is high this cycle: RX_DATA takes the byte and RX_VALID=1 next cycle.
    - Otherwise the byte is dropped and OVERRUN=1.
- Shift edge:
  - If bitcnt==0 (a byte boundary has just passed), reload txsh from the holding register or FILL, using the same rule as select.
  - Otherwise txsh <= {txsh[6:0], 1'b0}.
  - MISO follows txsh[7].
- TX handshake:
  - Transfer occurs when TX_VALID && TX_READY; TX_READY is !full, registered.
  - Consume and accept cannot occur in the same cycle.
  - TX_DATA is only sampled at transfer.
- RX handshake: a byte is consumed when RX_VALID && RX_READY.
- Deselect:
  - With bitcnt!=0, FRAME_ERR pulses for one cycle and the partial byte is discarded.
  - MISO_OE=0, MISO=1, BUSY=0.
  - The loaded-but-unsent TX byte is lost; the holding register is unaffected.
- OVERRUN:
  - CLR_OVR clears it.
  - If CLR_OVR coincides with a new overrun event, the set wins.
- RX completion and RX_READY in the same cycle: the old byte is consumed and the new byte is latched, with no overrun.

Optional Feature:
- Macro: SPI_RX_FIFO_EN.
- Defined:
  - Received bytes go to an RX_FIFO_DEPTH-entry FIFO.
  - RX_DATA/RX_VALID present the FIFO head.
  - OVERRUN is set only when the FIFO is full and no pop occurs in the same cycle. Simultaneous push and pop on a full FIFO succeeds.
  - The FIFO is cleared on reset only, not on deselect.
- Undefined: single RX holding register as described above. The RX_FIFO_DEPTH parameter is ignored.

Decomposition:
- Package spi_responder_pkg:
  - state encoding (IDLE, SELECTED);
  - byte width constant 8;
  - default FILL constant 8'hFF.
- Sub-module spi_pin_sync: a parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated for SCK, MOSI and nSS. MOSI uses the level output only.

Test Plan:
- Reset, CPOL=0, TX_DATA=8'hA5 pushed, select, then 8 SCK cycles with MOSI=8'h3C → MISO bits 1,0,1,0,0,1,0,1; RX_DATA=8'h3C, RX_VALID=1; TX_READY=1 after select.
- No TX pushed, 2-byte transfer with MOSI=8'h01,8'h80 and RX_READY high → MISO all ones (FILL); two RX_VALID events with 8'h01 then 8'h80.
- RX_READY held low, 2 bytes 8'h11,8'h22 → RX_DATA stays 8'h11, OVERRUN=1. CLR_OVR pulse → OVERRUN=0. With SPI_RX_FIFO_EN: both bytes are delivered in order and OVERRUN stays 0 until 5 bytes have arrived.
- Deselect after 5 SCK edges → FRAME_ERR single-cycle pulse, no RX_VALID. Next full byte 8'hC3 is received correctly, starting from bit 0.
- CPOL=1, SCK idle high, byte 8'h96 both directions → same data as the mode-0 case, sampled on falling edges.
- nRESET asserted mid-byte with nSS held low, then released → MISO_OE=0, BUSY=0, outputs at reset values. No RX byte until nSS toggles high then low.
